// File: rtl/text_write_arbiter.sv
// Two-requester write arbiter for an 80x30 character text buffer.
// Round-robin arbitration, optional blanking-interval gating, and a full-buffer clear sweep.
module text_write_arbiter #(
  parameter int                ADDR_W     = 12,
  parameter int                DEPTH      = 2400,
  parameter int                CHAR_W     = 7,
  parameter int                BLANK_ONLY = 1,
  parameter logic [CHAR_W-1:0] FILL_CHAR  = 7'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [CHAR_W-1:0] data0,
  input  logic [CHAR_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  input  logic              blank,
  input  logic              clear,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [CHAR_W-1:0] wdata,
  output logic              busy,
  output logic              clear_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0] state;
  logic       rr_ptr;      // requester favoured when both are eligible
  logic       winner;      // requester being serviced by the current WRITE/DONE pair
  logic       clear_pend;  // clear seen during WRITE/DONE, serviced at the next IDLE
  logic       elig0;
  logic       elig1;
  logic       grant_sel;

  // NOTE: every variable assigned in an always_comb block gets a value on every
  // path (here unconditionally), so no latch can be inferred.
  always_comb begin
    elig0     = req0 && (blank || (BLANK_ONLY == 0));
    elig1     = req1 && (blank || (BLANK_ONLY == 0));
    grant_sel = (elig0 && elig1) ? rr_ptr : elig1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every register, outputs included, has an explicit async reset value;
      // there is no storage array here that would need to be left unreset.
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      winner     <= 1'b0;
      clear_pend <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      clear_busy <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (clear || clear_pend) begin
            state      <= CLEAR;
            clear_pend <= 1'b0;
            we         <= 1'b1;
            waddr      <= '0;
            wdata      <= FILL_CHAR;
            busy       <= 1'b1;
            clear_busy <= 1'b1;
          end else if (elig0 || elig1) begin
            state  <= WRITE;
            winner <= grant_sel;
            we     <= 1'b1;
            waddr  <= grant_sel ? addr1 : addr0;
            wdata  <= grant_sel ? data1 : data0;
            busy   <= 1'b1;
          end
        end
        WRITE: begin
          if (clear) clear_pend <= 1'b1;
          state <= DONE;
          we    <= 1'b0;
          ack0  <= ~winner;
          ack1  <= winner;
        end
        DONE: begin
          if (clear) clear_pend <= 1'b1;
          state  <= IDLE;
          rr_ptr <= ~winner;
          busy   <= 1'b0;
        end
        CLEAR: begin
          // waddr doubles as the sweep counter; a clear pulse here is ignored
          if (waddr == LAST_ADDR) begin
            state      <= IDLE;
            we         <= 1'b0;
            busy       <= 1'b0;
            clear_busy <= 1'b0;
          end else begin
            waddr <= waddr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
